// File: rtl/prog_fsm.sv
// prog_fsm: table-driven Moore state machine whose transition graph
// can be rewritten at run time through a table write port.
module prog_fsm #(
   parameter int SW           = 3,
   parameter int IW           = 1,
   parameter int RESET_STATE  = 2,
   parameter int LOAD_DEFAULT = 1,
   parameter int CW           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    a,
   input  logic             en,
   input  logic             wr_en,
   input  logic [SW+IW-1:0] wr_addr,
   input  logic [SW:0]      wr_data,
   output logic [SW-1:0]    sd,
   output logic             err,
   output logic [CW-1:0]    trans_cnt
);

   localparam int DEPTH = 2 ** (SW + IW);
   localparam logic [SW-1:0] RST = SW'(RESET_STATE);

   logic [SW:0]      tbl [DEPTH];
   logic [SW+IW-1:0] raddr;
   logic [SW:0]      ent;

   // Built-in program; upper input bits are ignored so it replicates.
   function automatic logic [SW:0] dflt(input int idx);
      int st;
      int a0;
      int nx;
      st = idx % (2 ** SW);
      a0 = (idx >> SW) % 2;
      nx = -1;
      if (st == 2)      nx = 6;
      else if (st == 6) nx = (a0 == 1) ? 7 : 5;
      else if (st == 7) nx = 5;
      else if (st == 5) nx = 4;
      else if (st == 4) nx = (a0 == 1) ? 6 : 2;
      if (nx < 0 || LOAD_DEFAULT == 0 || SW < 3)
         return '0;
      return {1'b1, SW'(nx)};
   endfunction

   assign raddr = {a, sd};
   assign ent   = tbl[raddr];

   // Lookup sees the pre-edge table, so a same-cycle write is read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         sd        <= RST;
         err       <= 1'b0;
         trans_cnt <= '0;
         for (int i = 0; i < DEPTH; i++)
            tbl[i] <= dflt(i);
      end else begin
         if (en) begin
            if (ent[SW]) begin
               sd <= ent[SW-1:0];
               if (trans_cnt != {CW{1'b1}})
                  trans_cnt <= trans_cnt + CW'(1);
            end else begin
               sd  <= RST;
               err <= 1'b1;
            end
         end
         if (wr_en)
            tbl[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_prog_fsm.sv
// tb_prog_fsm: randomized + directed scoreboard bench for prog_fsm
// (one CW=8 instance and one CW=4 instance on shared stimulus).
module tb_prog_fsm;

   localparam int SW = 3;
   localparam int IW = 1;
   localparam int RS = 2;
   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [IW-1:0] a;
   logic         en;
   logic         wr_en;
   logic [3:0]   wr_addr;
   logic [3:0]   wr_data;
   logic [2:0]   sd, sd4;
   logic         err, err4;
   logic [7:0]   trans_cnt;
   logic [3:0]   trans_cnt4;

   typedef struct {
      int sd;
      int err;
      int cnt;
      int cnt4;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   done = 0;

   // reference model state
   int m_sd, m_err, m_cnt, m_cnt4;
   int m_valid [DEPTH];
   int m_next  [DEPTH];

   always #5 clk = ~clk;

   prog_fsm #(.SW(3), .IW(1), .RESET_STATE(2), .LOAD_DEFAULT(1), .CW(8)) dut (
      .clk(clk), .reset(reset), .a(a), .en(en), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .sd(sd), .err(err), .trans_cnt(trans_cnt)
   );

   prog_fsm #(.SW(3), .IW(1), .RESET_STATE(2), .LOAD_DEFAULT(1), .CW(4)) dut4 (
      .clk(clk), .reset(reset), .a(a), .en(en), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .sd(sd4), .err(err4), .trans_cnt(trans_cnt4)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Rule list: {state, a0, next}; a0=-1 means either input value.
   task automatic load_default();
      int rules [7][3] = '{'{2, -1, 6}, '{6, 1, 7}, '{6, 0, 5},
                           '{7, -1, 5}, '{5, -1, 4}, '{4, 1, 6}, '{4, 0, 2}};
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0;
         m_next[i]  = 0;
      end
      foreach (rules[r])
         for (int av = 0; av < 2; av++)
            if (rules[r][1] < 0 || rules[r][1] == av) begin
               m_valid[av * 8 + rules[r][0]] = 1;
               m_next[av * 8 + rules[r][0]]  = rules[r][2];
            end
   endtask

   task automatic step(input int ra, input int ren, input int rrst,
                       input int rwr = 0, input int waddr = 0,
                       input int wdata = 0);
      exp_t e;
      int idx;
      @(negedge clk);
      reset   = 1'(rrst);
      a       = 1'(ra);
      en      = 1'(ren);
      wr_en   = 1'(rwr);
      wr_addr = 4'(waddr);
      wr_data = 4'(wdata);
      if (rrst != 0) begin
         m_sd = RS; m_err = 0; m_cnt = 0; m_cnt4 = 0;
         load_default();
      end else begin
         if (ren != 0) begin
            idx = ra * 8 + m_sd;
            if (m_valid[idx] != 0) begin
               m_sd   = m_next[idx];
               m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
               m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
            end else begin
               m_sd  = RS;
               m_err = 1;
            end
         end
         if (rwr != 0) begin
            m_valid[waddr] = (wdata >> 3) & 1;
            m_next[waddr]  = wdata & 7;
         end
      end
      e.sd = m_sd; e.err = m_err; e.cnt = m_cnt; e.cnt4 = m_cnt4;
      exp_q.push_back(e);
   endtask

   // monitor: outputs are registered, so every edge presents a result
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sd", int'(sd), e.sd);
         chk("err", int'(err), e.err);
         chk("trans_cnt", int'(trans_cnt), e.cnt);
         chk("sd_cw4", int'(sd4), e.sd);
         chk("err_cw4", int'(err4), e.err);
         chk("trans_cnt_cw4", int'(trans_cnt4), e.cnt4);
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL timeout: got no finish, expected finish by 200000");
         $fatal(1, "timeout");
      end
   end

   initial begin
      int g;
      reset = 1'b0; a = '0; en = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      // default program, a=0: 2,6,5,4,2,6...
      step(0, 1, 1);
      for (int i = 0; i < 6; i++) step(0, 1, 0);

      // a=1: ...6,7,5,4,6...; then drop a at state 4
      step(0, 1, 1);
      for (int i = 0; i < 8; i++) step(1, 1, 0);
      g = 0;
      while (m_sd != 4 && g < 8) begin
         step(1, 1, 0);
         g++;
      end
      step(0, 1, 0);

      // illegal transition out of state 6 with a=0
      step(0, 1, 1);
      step(0, 0, 0, 1, 6, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      step(0, 1, 1);

      // read-before-write collision at address {0,2}
      step(0, 1, 1);
      step(0, 1, 0, 1, 2, 4'b1100);
      for (int i = 0; i < 5; i++) step(0, 1, 0);

      // hold for 5 cycles, then reset while enabled
      step(0, 1, 1);
      step(0, 1, 0);
      step(0, 1, 0);
      for (int i = 0; i < 5; i++) step($urandom_range(0, 1), 0, 0);
      step(0, 1, 0);
      step(0, 1, 1);

      // 20 enabled legal cycles: CW=4 instance saturates at 15
      for (int i = 0; i < 20; i++) step(0, 1, 0);

      // randomized traffic including reprogramming and illegal visits
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1),
              ($urandom_range(0, 3) != 0) ? 1 : 0,
              ($urandom_range(0, 49) == 0) ? 1 : 0,
              ($urandom_range(0, 9) == 0) ? 1 : 0,
              $urandom_range(0, 15),
              $urandom_range(0, 15));

      @(negedge clk);
      en = 1'b0; wr_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
